// File: rtl/matrix_storage_loader.sv
// Packs WORDS_PER_ROW stream words into one storage row and writes rows layer-major, row-minor.
// Last word accepted at edge N -> is_write in cycle N+1; in_ready is low outside LOAD, so upstream stalls while a row is written.
module matrix_storage_loader #(
    parameter int WORD_W        = 16,
    parameter int WORDS_PER_ROW = 3,
    parameter int IDX_W         = 32
) (
    input  logic                              clk_clk,
    input  logic                              reset_reset,
    input  logic                              start,
    input  logic [IDX_W-1:0]                  cfg_layers,
    input  logic [IDX_W-1:0]                  cfg_rows,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WORD_W-1:0]                 in_data,
    output logic                              is_write,
    output logic [IDX_W-1:0]                  write_layer_index,
    output logic [IDX_W-1:0]                  write_row_index,
    output logic [WORD_W*WORDS_PER_ROW-1:0]   write_data,
    output logic                              busy,
    output logic                              done
);
    localparam int ROW_W = WORD_W * WORDS_PER_ROW;
    localparam int CNT_W = $clog2(WORDS_PER_ROW + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [IDX_W-1:0] row_cnt;
    logic [IDX_W-1:0] layer_cnt;
    logic [IDX_W-1:0] layers_q;
    logic [IDX_W-1:0] rows_q;
    logic [ROW_W-1:0] pack;
    logic [ROW_W-1:0] pack_next;
    logic             row_last;
    logic             layer_last;

    // Current word dropped into its slot; word 0 lands in the LSBs.
    always_comb begin
        pack_next = pack;
        for (int k = 0; k < WORDS_PER_ROW; k++) begin
            if (word_cnt == CNT_W'(k))
                pack_next[k*WORD_W +: WORD_W] = in_data;
        end
    end

    assign row_last   = (row_cnt + IDX_W'(1)) == rows_q;
    assign layer_last = (layer_cnt + IDX_W'(1)) == layers_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state             <= IDLE;
            word_cnt          <= '0;
            row_cnt           <= '0;
            layer_cnt         <= '0;
            layers_q          <= '0;
            rows_q            <= '0;
            pack              <= '0;
            in_ready          <= 1'b0;
            is_write          <= 1'b0;
            write_layer_index <= '0;
            write_row_index   <= '0;
            write_data        <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        layers_q  <= cfg_layers;
                        rows_q    <= cfg_rows;
                        row_cnt   <= '0;
                        layer_cnt <= '0;
                        word_cnt  <= '0;
                        if (cfg_layers == '0 || cfg_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        pack <= pack_next;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt          <= '0;
                            state             <= WRITE;
                            in_ready          <= 1'b0;
                            is_write          <= 1'b1;
                            write_data        <= pack_next;
                            write_layer_index <= layer_cnt;
                            write_row_index   <= row_cnt;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    is_write <= 1'b0;
                    if (row_last) begin
                        row_cnt   <= '0;
                        layer_cnt <= layer_cnt + IDX_W'(1);
                    end else begin
                        row_cnt <= row_cnt + IDX_W'(1);
                    end
                    if (row_last && layer_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
